// File: rtl/aes_decrypt_top.sv
// AES-128 iterative decryptor: round keys are expanded once per key load into a
// register store, then each block retires one inverse round per clock.

package aes_dec_pkg;
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 built from the squares a^2..a^128; maps 0 to 0 as the S-box needs
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction
endpackage

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] d
);
   import aes_dec_pkg::*;
   logic [7:0] b;
   assign b = gf_inv(a);
   assign d = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] d
);
   import aes_dec_pkg::*;
   logic [7:0] b;
   assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   assign d = gf_inv(b);
endmodule

module aes_decrypt_top (
   input  logic         clk,
   input  logic         reset,
   input  logic         kld,
   input  logic [127:0] key,
   input  logic         ld,
   input  logic [127:0] text_in,
   output logic         key_rdy,
   output logic         done,
   output logic [127:0] text_out
);
   import aes_dec_pkg::*;

   typedef enum logic [1:0] {IDLE, KEXP, READY, DEC} state_t;

   state_t       state;
   logic [3:0]   rnd;
   logic [127:0] rk [0:10];
   logic [127:0] wk, st;

   // forward key schedule step: wk holds rk[10-rnd], produces rk[11-rnd]
   logic [31:0]  rot, sub, temp;
   logic [7:0]   rcon;
   logic [127:0] wk_next;

   always_comb begin
      case (rnd)
         4'd10:   rcon = 8'h01;
         4'd9:    rcon = 8'h02;
         4'd8:    rcon = 8'h04;
         4'd7:    rcon = 8'h08;
         4'd6:    rcon = 8'h10;
         4'd5:    rcon = 8'h20;
         4'd4:    rcon = 8'h40;
         4'd3:    rcon = 8'h80;
         4'd2:    rcon = 8'h1b;
         4'd1:    rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign rot = {wk[23:0], wk[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_ksbox
      aes_sbox u_sbox (.a(rot[8*i +: 8]), .d(sub[8*i +: 8]));
   end

   assign temp = sub ^ {rcon, 24'h0};
   assign wk_next[127:96] = wk[127:96] ^ temp;
   assign wk_next[95:64]  = wk[95:64]  ^ wk_next[127:96];
   assign wk_next[63:32]  = wk[63:32]  ^ wk_next[95:64];
   assign wk_next[31:0]   = wk[31:0]   ^ wk_next[63:32];

   // inverse round datapath; byte j of the state sits at [127-8j -: 8]
   logic [127:0] sr, sb, ak, mc, rkey;

   assign rkey = rk[rnd];

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
   end

   for (genvar j = 0; j < 16; j++) begin : g_isbox
      aes_inv_sbox u_isbox (.a(sr[8*j +: 8]), .d(sb[8*j +: 8]));
   end

   assign ak = sb ^ rkey;

   for (genvar c = 0; c < 4; c++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ak[127-32*c -: 8];
      assign a1 = ak[119-32*c -: 8];
      assign a2 = ak[111-32*c -: 8];
      assign a3 = ak[103-32*c -: 8];
      assign mc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      assign mc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      assign mc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      assign mc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
   end

   // rnd: 10 = initial AddRoundKey, 9..1 = full rounds, 0 = final round
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         key_rdy  <= 1'b0;
         done     <= 1'b0;
         text_out <= '0;
         rnd      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (kld) begin
               state <= KEXP;
               rk[0] <= key;
               wk    <= key;
               rnd   <= 4'd10;
            end
            KEXP: begin
               rk[4'd11 - rnd] <= wk_next;
               wk  <= wk_next;
               rnd <= rnd - 4'd1;
               if (rnd == 4'd1) begin
                  state   <= READY;
                  key_rdy <= 1'b1;
               end
            end
            READY: if (kld) begin
               state   <= KEXP;
               key_rdy <= 1'b0;
               rk[0]   <= key;
               wk      <= key;
               rnd     <= 4'd10;
            end else if (ld) begin
               state <= DEC;
               st    <= text_in;
               rnd   <= 4'd10;
            end
            DEC: begin
               if (rnd == 4'd0) begin
                  text_out <= ak;
                  done     <= 1'b1;
                  // a load on the completing edge starts the next block straight away
                  if (ld) begin
                     st  <= text_in;
                     rnd <= 4'd10;
                  end else begin
                     state <= READY;
                  end
               end else begin
                  st  <= (rnd == 4'd10) ? (st ^ rkey) : mc;
                  rnd <= rnd - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_decrypt_top.sv
// Bench for aes_decrypt_top: known-answer and model-encrypted vectors, scoreboard on done.

module tb_aes_decrypt_top;
   logic         clk = 1'b0;
   logic         reset, kld, ld;
   logic [127:0] key, text_in;
   logic         key_rdy, done;
   logic [127:0] text_out;

   always #5 clk = ~clk;

   aes_decrypt_top dut (
      .clk(clk), .reset(reset), .kld(kld), .key(key), .ld(ld), .text_in(text_in),
      .key_rdy(key_rdy), .done(done), .text_out(text_out)
   );

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

   int           n_vec = 0, n_err = 0, n_done = 0;
   logic [127:0] sbq [$];
   logic [7:0]   sbox [256];
   vec_t         vt [6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // S-box by walking the multiplicative group with generator 3
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // reference forward cipher, used to make ciphertexts for round-trip vectors
   function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] pt);
      logic [127:0] w, s, t;
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      w  = k;
      s  = pt ^ k;
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         tmp = {sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]], sbox[w[31:24]]} ^ {rc, 24'h0};
         w[127:96] = w[127:96] ^ tmp;
         w[95:64]  = w[95:64]  ^ w[127:96];
         w[63:32]  = w[63:32]  ^ w[95:64];
         w[31:0]   = w[31:0]   ^ w[63:32];
         rc = xt(rc);
         t = '0;
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
               t[127-8*(4*c+rr) -: 8] = sbox[s[127-8*(4*((c+rr)%4)+rr) -: 8]];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
               s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end else begin
            s = t;
         end
         s = s ^ w;
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_done++;
         if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got text_out %h with no block outstanding", text_out);
         end else begin
            chk("plaintext", text_out, sbq.pop_front());
         end
      end
   end

   // called at a negedge; kld sampled on the next rising edge
   task automatic load_key(input logic [127:0] k);
      int cyc;
      kld = 1'b1;
      key = k;
      @(negedge clk);
      kld = 1'b0;
      key = rnd128();
      cyc = 0;
      while (key_rdy !== 1'b1 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk_int("key_latency", cyc, 10);
   endtask

   task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt);
      int cyc;
      ld      = 1'b1;
      text_in = ct;
      sbq.push_back(pt);
      @(negedge clk);
      ld      = 1'b0;
      text_in = rnd128();
      cyc = 0;
      while (done !== 1'b1 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk_int("dec_latency", cyc, 11);
      @(negedge clk);
      chk_int("done_pulse", int'(done), 0);
      chk("text_out_hold", text_out, pt);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] cur, pt2, ct2;
      int base;
      build_sbox();
      vt[0] = '{K_C1, CT_C1, PT_C1};
      vt[1] = '{K_B, CT_B, PT_B};
      vt[2] = '{128'hcafebabedeadbeefdeadbeef00000000,
                enc(128'hcafebabedeadbeefdeadbeef00000000, 128'hbba47f76875f634a85d6fe52004297b4),
                128'hbba47f76875f634a85d6fe52004297b4};
      for (int i = 3; i < 6; i++) begin
         vt[i].key = rnd128();
         vt[i].pt  = rnd128();
         vt[i].ct  = enc(vt[i].key, vt[i].pt);
      end
      pt2 = rnd128();
      ct2 = enc(K_C1, pt2);

      // reset wins over both strobes
      reset = 1'b0; kld = 1'b1; ld = 1'b1; key = K_B; text_in = CT_B;
      repeat (3) @(negedge clk);
      chk_int("rst_key_rdy", int'(key_rdy), 0);
      chk_int("rst_done", int'(done), 0);
      chk("rst_text_out", text_out, '0);
      reset = 1'b1; kld = 1'b0; ld = 1'b0;

      // ld with no key loaded
      ld = 1'b1; text_in = CT_B;
      @(negedge clk);
      ld = 1'b0;
      repeat (15) @(negedge clk);
      chk_int("idle_ld_ignored", n_done, 0);
      chk_int("idle_key_rdy", int'(key_rdy), 0);

      load_key(K_B);
      chk("rk10", dut.rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      cur = K_B;

      for (int i = 0; i < 6; i++) begin
         if (vt[i].key !== cur) begin
            load_key(vt[i].key);
            cur = vt[i].key;
         end
         decrypt(vt[i].ct, vt[i].pt);
      end

      // second ld in the middle of a block
      load_key(K_C1);
      base = n_done;
      ld = 1'b1; text_in = CT_C1; sbq.push_back(PT_C1);
      @(negedge clk);
      ld = 1'b0;
      repeat (4) @(negedge clk);
      ld = 1'b1; text_in = CT_B;
      @(negedge clk);
      ld = 1'b0;
      repeat (6) @(negedge clk);
      chk_int("mid_dec_done", int'(done), 1);
      repeat (15) @(negedge clk);
      chk_int("mid_dec_single_done", n_done - base, 1);

      // kld and ld together in READY
      base = n_done;
      kld = 1'b1; ld = 1'b1; key = K_B; text_in = CT_C1;
      @(negedge clk);
      kld = 1'b0; ld = 1'b0;
      chk_int("kld_wins_key_rdy_low", int'(key_rdy), 0);
      repeat (14) @(negedge clk);
      chk_int("kld_wins_no_dec", n_done - base, 0);
      chk_int("kld_wins_key_rdy_high", int'(key_rdy), 1);
      decrypt(CT_B, PT_B);

      // reset at N+6 aborts the block
      ld = 1'b1; text_in = CT_B;
      @(negedge clk);
      ld = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_text_out", text_out, '0);
      chk_int("abort_key_rdy", int'(key_rdy), 0);
      chk_int("abort_done", int'(done), 0);
      base = n_done;
      repeat (15) @(negedge clk);
      chk_int("abort_no_done", n_done - base, 0);
      ld = 1'b1; text_in = CT_B;
      @(negedge clk);
      ld = 1'b0;
      repeat (15) @(negedge clk);
      chk_int("abort_ld_needs_key", n_done - base, 0);
      load_key(K_B);
      decrypt(CT_B, PT_B);

      // back-to-back blocks at N and N+11
      load_key(K_C1);
      ld = 1'b1; text_in = CT_C1; sbq.push_back(PT_C1);
      @(negedge clk);
      ld = 1'b0; text_in = rnd128();
      repeat (10) @(negedge clk);
      chk_int("b2b_done_n10", int'(done), 0);
      ld = 1'b1; text_in = ct2; sbq.push_back(pt2);
      @(negedge clk);
      chk_int("b2b_done_n11", int'(done), 1);
      ld = 1'b0; text_in = rnd128();
      repeat (10) @(negedge clk);
      chk_int("b2b_done_n21", int'(done), 0);
      @(negedge clk);
      chk_int("b2b_done_n22", int'(done), 1);
      @(negedge clk);
      chk_int("b2b_done_n23", int'(done), 0);

      chk_int("scoreboard_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
